// File: rtl/wb_ddr_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one DDR slave port (wb2axi bridge)
// among NUM_MASTERS requesters, with a strobe watchdog that errors out stuck cycles.
//
// state | meaning
// IDLE  | no owner; round-robin pick among masters asserting m_cyc_i
// BUSY  | owner's bus passed through to slave, responses routed back to owner
// DRAIN | watchdog fired; slave side parked, waiting for owner to drop m_cyc_i
module wb_ddr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 1023
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_MASTERS-1:0]                   m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                   m_stb_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0][2:0]              m_cti_i,
  input  logic [NUM_MASTERS-1:0][1:0]              m_bte_i,
  output logic [NUM_MASTERS-1:0]                   m_ack_o,
  output logic [NUM_MASTERS-1:0]                   m_err_o,
  output logic [NUM_MASTERS-1:0]                   m_rty_o,
  output logic [DATA_WIDTH-1:0]                    m_dat_o,
  output logic                                     s_cyc_o,
  output logic                                     s_stb_o,
  output logic                                     s_we_o,
  output logic [ADDR_WIDTH-1:0]                    s_adr_o,
  output logic [DATA_WIDTH-1:0]                    s_dat_o,
  output logic [DATA_WIDTH/8-1:0]                  s_sel_o,
  output logic [2:0]                               s_cti_o,
  output logic [1:0]                               s_bte_o,
  input  logic                                     s_ack_i,
  input  logic                                     s_err_i,
  input  logic                                     s_rty_i,
  input  logic [DATA_WIDTH-1:0]                    s_dat_i,
  output logic [NUM_MASTERS-1:0]                   grant_o,
  output logic                                     timeout_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [WD_W-1:0]        wd_cnt;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   slv_resp;
  logic                   owner_cyc;
  logic                   expire;
  int                     scan_idx;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      scan_idx = (int'(last_grant) + 1 + i) % NUM_MASTERS;
      if (!pick_valid && m_cyc_i[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(scan_idx);
      end
    end
  end

  assign slv_resp  = s_ack_i | s_err_i | s_rty_i;
  assign owner_cyc = m_cyc_i[owner];
  // A slave response in the expiry cycle takes precedence over the watchdog.
  assign expire    = (state == BUSY) && owner_cyc && (wd_cnt == WD_W'(TIMEOUT)) && !slv_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      grant_o    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      grant_o    <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    grant_nxt      = grant_o;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BUSY;
          owner_nxt = pick_idx;
          grant_nxt = NUM_MASTERS'(1) << pick_idx;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
          grant_nxt      = '0;
        end else if (expire) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!owner_cyc) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
          grant_nxt      = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!s_stb_o || slv_resp) begin
      wd_cnt <= '0;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    timeout_o = expire;
    if (state == BUSY) begin
      s_cyc_o        = m_cyc_i[owner];
      s_stb_o        = m_stb_i[owner];
      s_we_o         = m_we_i[owner];
      s_adr_o        = m_adr_i[owner];
      s_dat_o        = m_dat_i[owner];
      s_sel_o        = m_sel_i[owner];
      s_cti_o        = m_cti_i[owner];
      s_bte_o        = m_bte_i[owner];
      m_ack_o[owner] = s_ack_i;
      m_rty_o[owner] = s_rty_i;
      m_err_o[owner] = s_err_i | expire;
    end
  end

  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Directed bench for wb_ddr_arbiter: two masters, TIMEOUT=15, hand-computed
// expectations for grant order, burst ownership, watchdog and reset behaviour.
module tb_wb_ddr_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       m_cyc_i, m_stb_i, m_we_i;
  logic [1:0][29:0] m_adr_i;
  logic [1:0][31:0] m_dat_i;
  logic [1:0][3:0]  m_sel_i;
  logic [1:0][2:0]  m_cti_i;
  logic [1:0][1:0]  m_bte_i;
  logic [1:0]       m_ack_o, m_err_o, m_rty_o;
  logic [31:0]      m_dat_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [29:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic [31:0]      s_dat_i;
  logic [1:0]       grant_o;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;

  wb_ddr_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n   = 1'b0;
    m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
    m_adr_i[0] = 30'h0000_1000; m_adr_i[1] = 30'h0000_2000;
    m_dat_i[0] = 32'hA0A0_A0A0; m_dat_i[1] = 32'hB1B1_B1B1;
    m_sel_i[0] = 4'hF;          m_sel_i[1] = 4'h3;
    m_cti_i[0] = 3'b000;        m_cti_i[1] = 3'b000;
    m_bte_i    = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 32'hDEAD_BEEF;

    // reset state
    tick(); tick();
    s_ack_i = 1'b1; #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_ack", 32'(m_ack_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("m_dat_bcast", m_dat_o, 32'hDEAD_BEEF);
    s_ack_i = 1'b0;

    // release with both masters requesting: master 0 first
    @(negedge clk);
    rst_n = 1'b1; m_cyc_i = 2'b11; m_stb_i = 2'b11;
    tick(); #1;
    chk("first_grant", 32'(grant_o), 32'h1);
    chk("first_s_cyc", 32'(s_cyc_o), 32'h1);
    chk("first_s_adr", 32'(s_adr_o), 32'h0000_1000);
    s_ack_i = 1'b1; #1;
    chk("first_ack_route", 32'(m_ack_o), 32'h1);
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; s_ack_i = 1'b0;
    tick(); #1;
    chk("gap_grant", 32'(grant_o), 32'h0);
    chk("gap_s_cyc", 32'(s_cyc_o), 32'h0);
    tick(); #1;
    chk("second_grant", 32'(grant_o), 32'h2);
    chk("second_s_adr", 32'(s_adr_o), 32'h0000_2000);

    // master 1 burst while master 0 waits
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_cti_i[1] = (b == 3) ? 3'b111 : 3'b010;
      s_ack_i = 1'b1; #1;
      chk("burst_ack", 32'(m_ack_o), 32'h2);
      chk("burst_grant", 32'(grant_o), 32'h2);
      chk("burst_cti", 32'(s_cti_o), (b == 3) ? 32'h7 : 32'h2);
      tick();
    end
    s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; m_cti_i[1] = 3'b000;
    #1;
    chk("burst_end_grant", 32'(grant_o), 32'h2);
    tick(); #1;
    chk("burst_release", 32'(grant_o), 32'h0);
    tick(); #1;
    chk("m0_after_burst", 32'(grant_o), 32'h1);

    // both request continuously: grants alternate
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    for (int t = 0; t < 10; t++) begin
      #1;
      chk("alt_grant", 32'(grant_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      s_ack_i = 1'b1; #1;
      chk("alt_ack", 32'(m_ack_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      s_ack_i = 1'b0;
      m_cyc_i[t % 2] = 1'b0; m_stb_i[t % 2] = 1'b0;
      tick();
      m_cyc_i[t % 2] = 1'b1; m_stb_i[t % 2] = 1'b1;
      tick();
    end
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    tick(); tick();
    chk("alt_idle", 32'(grant_o), 32'h0);

    // watchdog expiry: master 1 alone, slave silent (last owner was 0)
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    tick(); #1;
    chk("wd_stb_rise", 32'(s_stb_o), 32'h1);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("wd_no_err_early", 32'(m_err_o), 32'h0);
      chk("wd_no_to_early", 32'(timeout_o), 32'h0);
    end
    tick(); #1;
    chk("wd_err", 32'(m_err_o), 32'h2);
    chk("wd_timeout", 32'(timeout_o), 32'h1);
    chk("wd_cyc_still", 32'(s_cyc_o), 32'h1);
    tick(); #1;
    chk("drain_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("drain_s_stb", 32'(s_stb_o), 32'h0);
    chk("drain_to_clear", 32'(timeout_o), 32'h0);
    chk("drain_err_clear", 32'(m_err_o), 32'h0);
    chk("drain_grant", 32'(grant_o), 32'h2);
    s_ack_i = 1'b1; #1;
    chk("drain_late_ack", 32'(m_ack_o), 32'h0);
    s_ack_i = 1'b0;
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    tick(); #1;
    chk("drain_exit", 32'(grant_o), 32'h0);

    // response coincides with expiry: response wins
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    tick();
    for (int k = 1; k < 16; k++) tick();
    s_ack_i = 1'b1; #1;
    chk("tie_ack", 32'(m_ack_o), 32'h1);
    chk("tie_no_err", 32'(m_err_o), 32'h0);
    chk("tie_no_timeout", 32'(timeout_o), 32'h0);
    tick();
    s_ack_i = 1'b0; #1;
    chk("tie_still_busy", 32'(s_cyc_o), 32'h1);
    chk("tie_cnt_cleared", 32'(timeout_o), 32'h0);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    tick(); tick();

    // reset during beat 2 of a master 1 burst (last owner was 0)
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_cti_i[1] = 3'b010;
    tick();
    s_ack_i = 1'b1; #1;
    chk("rb_beat1", 32'(m_ack_o), 32'h2);
    tick();
    #1; rst_n = 1'b0; #1;
    chk("rb_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rb_s_stb", 32'(s_stb_o), 32'h0);
    chk("rb_s_adr", 32'(s_adr_o), 32'h0);
    chk("rb_ack", 32'(m_ack_o), 32'h0);
    chk("rb_grant", 32'(grant_o), 32'h0);
    tick();
    rst_n = 1'b1; s_ack_i = 1'b0;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_cti_i[1] = 3'b000;
    tick(); #1;
    chk("post_rst_grant", 32'(grant_o), 32'h1);
    chk("post_rst_s_cyc", 32'(s_cyc_o), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ddr_arbiter.md
WB_DDR_ARBITER -- requirements
Module: wb_ddr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone B3 requesters sharing the DDR port (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 30, Wishbone byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width; sel width is DATA_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum cycles a slave strobe may stay unanswered.
REQ-005 SHALL have ports `clk` (input, 1 bit), the single clock, and `rst_n` (input, 1 bit), the reset, which is asynchronous and active-low.
REQ-006 SHALL have master-side inputs, each an array indexed by master:
- m_cyc_i, m_stb_i, m_we_i: NUM_MASTERS x 1
- m_adr_i: NUM_MASTERS x ADDR_WIDTH
- m_dat_i: NUM_MASTERS x DATA_WIDTH
- m_sel_i: NUM_MASTERS x DATA_WIDTH/8
- m_cti_i: NUM_MASTERS x 3
- m_bte_i: NUM_MASTERS x 2
REQ-007 SHALL have master-side outputs:
- m_ack_o, m_err_o, m_rty_o: NUM_MASTERS x 1
- m_dat_o: DATA_WIDTH, broadcast to all masters
REQ-008 SHALL have slave-side outputs: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o (widths as the master side), toward the wb2axi bridge.
REQ-009 SHALL have slave-side inputs: s_ack_i, s_err_i, s_rty_i (1 bit each) and s_dat_i (DATA_WIDTH).
REQ-010 SHALL have status output grant_o (NUM_MASTERS bits): one-hot current owner, all zero when idle.
REQ-011 SHALL have status output timeout_o (1 bit): one-cycle pulse on a watchdog expiry.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DRAIN, held in registers.
REQ-013 IDLE arbitration: among masters with m_cyc_i=1, SHALL pick the first found round-robin, starting at (last_grant+1) mod NUM_MASTERS.
REQ-014 On a pick, SHALL register grant_o and enter BUSY on the next edge; latency from m_cyc_i rising to s_cyc_o=1 is exactly 1 cycle.
REQ-015 In BUSY, SHALL drive all s_* outputs combinationally from the granted master's inputs.
REQ-016 When not in BUSY, SHALL hold all s_* outputs at 0.
REQ-017 SHALL route s_ack_i, s_err_i and s_rty_i combinationally to the granted master only; all other masters see 0.
REQ-018 SHALL drive m_dat_o = s_dat_i at all times.
REQ-019 Ownership SHALL persist while the granted master holds m_cyc_i=1, including incrementing bursts (cti=010) and back-to-back cycles; no preemption.
REQ-020 In BUSY, when the granted m_cyc_i=0, SHALL return to IDLE next edge, update last_grant to the owner, and clear grant_o; at least one idle cycle separates any two grants.
REQ-021 SHALL keep a watchdog counter (width clog2(TIMEOUT+1)):
- reset to 0 whenever s_stb_o=0 or any of s_ack_i/s_err_i/s_rty_i=1
- otherwise incremented by 1 per cycle, saturating
REQ-022 When the watchdog counter equals TIMEOUT in BUSY, SHALL pulse m_err_o to the owner and timeout_o for one cycle, then enter DRAIN.
REQ-023 In DRAIN, SHALL force s_cyc_o and s_stb_o to 0, ignore late slave responses, and return to IDLE once the owner's m_cyc_i=0, updating last_grant to the owner.
REQ-024 If a slave response and watchdog expiry coincide, the response SHALL win: it is forwarded, the counter clears, and no error is raised.
REQ-025 SHALL treat a request from a master that drops m_cyc_i in the same cycle it is picked as a normal grant that releases in the next cycle.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously set the state to IDLE, grant_o=0, timeout_o=0, the watchdog counter to 0 and last_grant=NUM_MASTERS-1, so master 0 has first priority.
REQ-027 While in reset, all s_* outputs and m_ack_o/m_err_o/m_rty_o SHALL be 0.
REQ-028 Reset asserted mid-burst SHALL abort the transfer immediately, with no further responses forwarded; after release, the arbiter restarts from IDLE.

Verification
REQ-029 Reset release, m_cyc_i=2'b11 at the same edge -> grant_o=01 one cycle later; after master 0 releases, one idle cycle, then grant_o=10.
REQ-030 Master 1 performs a 4-beat burst (cti 010,010,010,111) while master 0 requests -> 4 acks delivered to master 1 only; master 0 granted only after master 1 drops m_cyc_i.
REQ-031 Both masters request continuously for 10 transactions -> grants alternate 0,1,0,1,...; no master granted twice in a row.
REQ-032 Slave never acks, TIMEOUT=15 -> m_err_o[owner] and timeout_o pulse once 15 cycles after s_stb_o rises; s_cyc_o=0 from the next cycle; a late s_ack_i is not forwarded.
REQ-033 s_ack_i arrives in the same cycle the counter reaches TIMEOUT -> ack forwarded, no err, no timeout_o.
REQ-034 rst_n pulled low for 1 cycle during beat 2 of a burst -> all outputs 0 asynchronously; after release, m_cyc_i=01 -> grant_o=01 after 1 cycle.
